// File: rtl/rca_wb_sequencer_if.sv
// Commit-side and register-file-side signals of the writeback sequencer.
// slave = sequencer view, master = producer / register-file view.
interface rca_wb_sequencer_if #(
    parameter int XLEN            = 32,
    parameter int NUM_WRITE_PORTS = 2
);
    logic                                 wb_committing;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] port_data;
    logic [NUM_WRITE_PORTS-1:0][4:0]      port_rd;
    logic [NUM_WRITE_PORTS-1:0]           port_en;
    logic                                 wb_accept;
    logic                                 rf_wr_valid;
    logic [4:0]                           rf_wr_addr;
    logic [XLEN-1:0]                      rf_wr_data;
    logic                                 rf_wr_ack;
    logic                                 group_done;
    logic                                 wb_overflow;

    modport slave (
        input  wb_committing, port_data, port_rd, port_en, rf_wr_ack,
        output wb_accept, rf_wr_valid, rf_wr_addr, rf_wr_data, group_done, wb_overflow
    );

    modport master (
        output wb_committing, port_data, port_rd, port_en, rf_wr_ack,
        input  wb_accept, rf_wr_valid, rf_wr_addr, rf_wr_data, group_done, wb_overflow
    );
endinterface

// File: rtl/rca_wb_sequencer.sv
// Buffers grid commit groups and serialises their enabled ports into single RF writes; first write one cycle after push,
// each write held until rf_wr_ack, commits refused (sticky wb_overflow) when full. RCA_WB_X0_SKIP_EN drops x0 writes at push.
module rca_wb_sequencer #(
    parameter int XLEN            = 32,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int GROUP_DEPTH     = 2
) (
    input logic               clk,
    input logic               rst,
    rca_wb_sequencer_if.slave bus
);
    localparam int PW = (GROUP_DEPTH > 1) ? $clog2(GROUP_DEPTH) : 1;
    localparam int CW = $clog2(GROUP_DEPTH + 1);
    localparam int IW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(GROUP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(GROUP_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        POP   = 2'd2
    } state_t;

    typedef logic [NUM_WRITE_PORTS-1:0] mask_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    mask_t         mask_q, mask_d;
    logic          overflow_q, overflow_d;

    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] data_q [GROUP_DEPTH];
    logic [NUM_WRITE_PORTS-1:0][4:0]      rd_q   [GROUP_DEPTH];
    mask_t                                en_q   [GROUP_DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    mask_t           push_en;
    mask_t           head_en;
    logic [IW-1:0]   sel;
    logic            wr_valid;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign accept  = (count_q < DEPTH_C);
    assign push    = bus.wb_committing && accept;
    assign head_en = en_q[head_q];

    always_comb begin
        push_en = bus.port_en;
`ifdef RCA_WB_X0_SKIP_EN
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (bus.port_rd[p] == 5'd0) begin
                push_en[p] = 1'b0;
            end
        end
`endif
    end

    // Lowest remaining port of the head group; descending scan so the lowest wins.
    always_comb begin
        sel = '0;
        for (int p = NUM_WRITE_PORTS - 1; p >= 0; p--) begin
            if (mask_q[p]) begin
                sel = IW'(p);
            end
        end
    end

    // IDLE also looks at a push into an empty queue so the first write appears the cycle after the push.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        pop      = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (head_en != '0) begin
                        state_d = ISSUE;
                        mask_d  = head_en;
                    end else begin
                        state_d = POP;
                    end
                end else if (push) begin
                    if (push_en != '0) begin
                        state_d = ISSUE;
                        mask_d  = push_en;
                    end else begin
                        state_d = POP;
                    end
                end
            end
            ISSUE: begin
                wr_valid = 1'b1;
                wr_addr  = rd_q[head_q][sel];
                wr_data  = data_q[head_q][sel];
                if (bus.rf_wr_ack) begin
                    mask_d      = mask_q;
                    mask_d[sel] = 1'b0;
                    if (mask_d == '0) begin
                        state_d = POP;
                    end
                end
            end
            POP: begin
                done    = 1'b1;
                pop     = 1'b1;
                mask_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
            end
        endcase
    end

    always_comb begin
        tail_d     = push ? ptr_inc(tail_q) : tail_q;
        head_d     = pop ? ptr_inc(head_q) : head_q;
        overflow_d = overflow_q | (bus.wb_committing & ~accept);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mask_q     <= mask_d;
            overflow_q <= overflow_d;
        end
    end

    // Group payload needs no reset: it is only read while count_q covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= bus.port_data;
            rd_q[tail_q]   <= bus.port_rd;
            en_q[tail_q]   <= push_en;
        end
    end

    assign bus.wb_accept   = accept;
    assign bus.rf_wr_valid = wr_valid;
    assign bus.rf_wr_addr  = wr_addr;
    assign bus.rf_wr_data  = wr_data;
    assign bus.group_done  = done;
    assign bus.wb_overflow = overflow_q;
endmodule
